// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the muldiv_seq sequencer: FSM state encoding,
// the ALU unit select for multiply/divide, default latencies, counter
// width and the helper that turns an operation into a counter preload.
package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0]  T_MULDIV    = 3'd3;
    localparam int unsigned MUL_LAT_DEF = 2;
    localparam int unsigned DIV_LAT_DEF = 18;
    localparam int unsigned CNT_W       = 6;

    // Preload value is N-1: the counter reaching zero marks the capture cycle.
    function automatic logic [CNT_W-1:0] lat_load(input logic [2:0]  t,
                                                  input logic [2:0]  func,
                                                  input int unsigned mul_lat,
                                                  input int unsigned div_lat);
        int unsigned n;
        if (t == T_MULDIV) n = func[1] ? div_lat : mul_lat;
        else               n = 1;
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Bundle of the request, ALU drive/return and result handshake signals of
// muldiv_seq. The sequencer connects through the slave modport; the
// microcode stage / ALU side (or a bench) uses the master modport.
//   start/ready           request handshake
//   op_*                  operation to issue
//   alu_*  (out of seq)   registered operand drive to the ALU
//   alu_out/oflags/div_exc ALU return values
//   res_*/res_ack         captured result handshake
interface muldiv_seq_if;

    logic        start;
    logic        ready;
    logic [31:0] op_x;
    logic [15:0] op_y;
    logic [2:0]  op_t;
    logic [2:0]  op_func;
    logic        op_word;
    logic [15:0] op_iflags;
    logic [15:0] op_seg;
    logic [15:0] op_off;

    logic [31:0] alu_x;
    logic [15:0] alu_y;
    logic [2:0]  alu_t;
    logic [2:0]  alu_func;
    logic        alu_word_op;
    logic [15:0] alu_iflags;
    logic [15:0] alu_seg;
    logic [15:0] alu_off;
    logic [31:0] alu_out;
    logic [8:0]  alu_oflags;
    logic        alu_div_exc;

    logic        res_valid;
    logic [31:0] res_out;
    logic [8:0]  res_flags;
    logic        res_exc;
    logic        res_ack;

    modport slave (
        input  start, op_x, op_y, op_t, op_func, op_word, op_iflags, op_seg, op_off,
        input  alu_out, alu_oflags, alu_div_exc, res_ack,
        output ready, alu_x, alu_y, alu_t, alu_func, alu_word_op, alu_iflags,
        output alu_seg, alu_off, res_valid, res_out, res_flags, res_exc
    );

    modport master (
        output start, op_x, op_y, op_t, op_func, op_word, op_iflags, op_seg, op_off,
        output alu_out, alu_oflags, alu_div_exc, res_ack,
        input  ready, alu_x, alu_y, alu_t, alu_func, alu_word_op, alu_iflags,
        input  alu_seg, alu_off, res_valid, res_out, res_flags, res_exc
    );

endinterface

// File: rtl/muldiv_seq_lat_cnt.sv
// lat_cnt: loadable down-counter that times the execute phase.
//   clk, rst  clock, synchronous active-high reset (clears to 0)
//   load      load load_val (has priority over counting)
//   load_val  preload value
//   en        count down; holds at zero
//   zero      counter equals zero
module lat_cnt
    import muldiv_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)                   cnt <= '0;
        else if (load)             cnt <= load_val;
        else if (en && cnt != '0)  cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: issues one ALU operation at a time, holds the operands for
// the unit's latency (1 cycle, MUL_LAT or DIV_LAT), captures result, flags
// and divide exception, and offers them on a valid/ack handshake.
//   clk, rst  clock, synchronous active-high reset
//   bus       muldiv_seq_if.slave: start/ready, op_*, alu_*, res_*/res_ack
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

    state_t      state, state_nxt;
    logic        ready, res_valid, accept, cnt_zero, is_div;

    logic [31:0] alu_x;
    logic [15:0] alu_y;
    logic [2:0]  alu_t;
    logic [2:0]  alu_func;
    logic        alu_word_op;
    logic [15:0] alu_iflags;
    logic [15:0] alu_seg;
    logic [15:0] alu_off;
    logic [31:0] res_out;
    logic [8:0]  res_flags;
    logic        res_exc;

    assign accept = bus.start && ready;
    assign is_div = (alu_t == T_MULDIV) && alu_func[1];

    lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (lat_load(bus.op_t, bus.op_func, MUL_LAT, DIV_LAT)),
        .en       (state == RUN),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt_zero) state_nxt = DONE;
            DONE:    if (bus.res_ack) state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: only ready looks past the state register (at res_ack).
    always_comb begin
        ready     = (state == IDLE) || (state == DONE && bus.res_ack);
        res_valid = (state == DONE);
    end

    // Operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x       <= '0;
            alu_y       <= '0;
            alu_t       <= '0;
            alu_func    <= '0;
            alu_word_op <= 1'b0;
            alu_iflags  <= '0;
            alu_seg     <= '0;
            alu_off     <= '0;
            res_out     <= '0;
            res_flags   <= '0;
            res_exc     <= 1'b0;
        end else begin
            if (accept) begin
                alu_x       <= bus.op_x;
                alu_y       <= bus.op_y;
                alu_t       <= bus.op_t;
                alu_func    <= bus.op_func;
                alu_word_op <= bus.op_word;
                alu_iflags  <= bus.op_iflags;
                alu_seg     <= bus.op_seg;
                alu_off     <= bus.op_off;
            end
            if (state == RUN && cnt_zero) begin
                res_out   <= bus.alu_out;
                res_flags <= bus.alu_oflags;
                // alu_div_exc is meaningless outside a divide
                res_exc   <= is_div ? bus.alu_div_exc : 1'b0;
            end
        end
    end

    assign bus.ready       = ready;
    assign bus.res_valid   = res_valid;
    assign bus.alu_x       = alu_x;
    assign bus.alu_y       = alu_y;
    assign bus.alu_t       = alu_t;
    assign bus.alu_func    = alu_func;
    assign bus.alu_word_op = alu_word_op;
    assign bus.alu_iflags  = alu_iflags;
    assign bus.alu_seg     = alu_seg;
    assign bus.alu_off     = alu_off;
    assign bus.res_out     = res_out;
    assign bus.res_flags   = res_flags;
    assign bus.res_exc     = res_exc;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a small behavioural ALU on the alu_*
// side. Flags are packed {OF, iflags[10:8], SF, ZF, AF, PF, CF}.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    muldiv_seq_if bus ();

    muldiv_seq #(.MUL_LAT(2), .DIV_LAT(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU. div_exc follows y==0 for every unit so the
    // sequencer's gating of res_exc is observable.
    always_comb begin
        logic [31:0] p, q, r;
        logic [8:0]  s;
        bus.alu_out     = bus.alu_x;
        bus.alu_oflags  = '0;
        bus.alu_div_exc = (bus.alu_y == 16'h0);
        p = '0; q = '0; r = '0; s = '0;
        if (bus.alu_t == 3'd3 && bus.alu_func[1]) begin
            if (bus.alu_y == 16'h0) begin
                bus.alu_out = 32'hFFFF_FFFF;
            end else begin
                q = bus.alu_x / {16'h0, bus.alu_y};
                r = bus.alu_x % {16'h0, bus.alu_y};
                bus.alu_out = {r[15:0], q[15:0]};
            end
        end else if (bus.alu_t == 3'd3) begin
            p = {16'h0, bus.alu_x[15:0]} * {16'h0, bus.alu_y};
            bus.alu_out = p;
            bus.alu_oflags[0] = (p[31:16] != 16'h0);
            bus.alu_oflags[8] = (p[31:16] != 16'h0);
        end else if (bus.alu_t == 3'd1) begin
            s = {1'b0, bus.alu_x[7:0]} + {1'b0, bus.alu_y[7:0]};
            bus.alu_out = {24'h0, s[7:0]};
            bus.alu_oflags = {1'b0, bus.alu_iflags[10:8], s[7], (s[7:0] == 8'h0),
                              bus.alu_x[4] ^ bus.alu_y[4] ^ s[4], ~^s[7:0], s[8]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] x, input logic [15:0] y, input logic [2:0] t,
                          input logic [2:0] func, input logic word);
        bus.op_x = x; bus.op_y = y; bus.op_t = t; bus.op_func = func; bus.op_word = word;
    endtask

    // Issue one op, wait (bounded) for res_valid, check, then acknowledge.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [15:0] y,
                          input logic [2:0] t, input logic [2:0] func, input logic word,
                          input int exp_lat, input logic [31:0] exp_out,
                          input logic [31:0] out_mask, input logic [8:0] exp_flags,
                          input logic [8:0] flag_mask, input logic exp_exc);
        int   lat;
        logic stable;
        set_op(x, y, t, func, word);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        stable = 1'b1;
        while (!bus.res_valid && lat < 100) begin
            if (bus.alu_x !== x || bus.alu_y !== y || bus.alu_t !== t ||
                bus.alu_func !== func || bus.alu_word_op !== word) stable = 1'b0;
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " res_out"}, bus.res_out & out_mask, exp_out & out_mask);
        check({tag, " res_flags"}, {23'h0, bus.res_flags & flag_mask}, {23'h0, exp_flags & flag_mask});
        check({tag, " res_exc"}, {31'h0, bus.res_exc}, {31'h0, exp_exc});
        check({tag, " alu stable"}, {31'h0, stable}, 32'h1);
        bus.res_ack = 1'b1;
        tick();
        bus.res_ack = 1'b0;
        #1;
        check({tag, " idle ready"}, {31'h0, bus.ready}, 32'h1);
        check({tag, " idle valid"}, {31'h0, bus.res_valid}, 32'h0);
    endtask

    initial begin
        bus.start = 1'b0; bus.res_ack = 1'b0;
        bus.op_iflags = '0; bus.op_seg = 16'h1234; bus.op_off = 16'h5678;
        set_op('0, '0, '0, '0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        check("reset ready", {31'h0, bus.ready}, 32'h1);
        check("reset valid", {31'h0, bus.res_valid}, 32'h0);
        check("reset res_out", bus.res_out, 32'h0);
        check("reset alu_t", {29'h0, bus.alu_t}, 32'h0);

        // word multiply 3*4
        run_op("mul", 32'h3, 16'h4, 3'd3, 3'd0, 1'b1, 3, 32'h0000_000C, '1, 9'h000, 9'h101, 1'b0);
        // word divide 100/7 -> rem 2, quot 14
        run_op("div", 32'h64, 16'h7, 3'd3, 3'b010, 1'b1, 19, 32'h0002_000E, '1, 9'h000, 9'h000, 1'b0);

        // reset five cycles into a divide
        set_op(32'h64, 16'h7, 3'd3, 3'b010, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("middiv valid", {31'h0, bus.res_valid}, 32'h0);
        check("middiv ready", {31'h0, bus.ready}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst ready", {31'h0, bus.ready}, 32'h1);
        check("rst valid", {31'h0, bus.res_valid}, 32'h0);
        check("rst res_out", bus.res_out, 32'h0);
        check("rst alu_x", bus.alu_x, 32'h0);
        check("rst alu_y", {16'h0, bus.alu_y}, 32'h0);
        check("rst alu_t/func", {26'h0, bus.alu_t, bus.alu_func}, 32'h0);
        check("rst alu_seg/off", {bus.alu_seg, bus.alu_off}, 32'h0);

        // multiply after reset: 0x1234*0x10, high word nonzero -> CF=OF=1
        run_op("mul2", 32'h1234, 16'h10, 3'd3, 3'd0, 1'b1, 3, 32'h0001_2340, '1, 9'h101, 9'h101, 1'b0);
        // multiply by zero: ALU raises div_exc, sequencer must not pass it on
        run_op("mul0", 32'h9, 16'h0, 3'd3, 3'd0, 1'b1, 3, 32'h0, '1, 9'h000, 9'h101, 1'b0);
        // divide by zero
        run_op("div0", 32'h64, 16'h0, 3'd3, 3'b010, 1'b1, 19, 32'hFFFF_FFFF, '1, 9'h000, 9'h000, 1'b1);
        // byte add 0xFF+0x01: low byte 0, CF, AF, ZF set
        run_op("badd", 32'hFF, 16'h1, 3'd1, 3'd0, 1'b0, 2, 32'h0, 32'hFF, 9'h00D, 9'h00D, 1'b0);

        // start held through RUN is ignored; ack+start in DONE chains
        set_op(32'h5, 16'h6, 3'd3, 3'd0, 1'b1);
        bus.start = 1'b1;
        tick();
        check("b2b run ready", {31'h0, bus.ready}, 32'h0);
        bus.op_x = 32'h7;
        tick();
        check("b2b held alu_x", bus.alu_x, 32'h5);
        check("b2b not valid", {31'h0, bus.res_valid}, 32'h0);
        tick();
        check("b2b valid", {31'h0, bus.res_valid}, 32'h1);
        check("b2b res_out", bus.res_out, 32'd30);
        check("b2b done noack ready", {31'h0, bus.ready}, 32'h0);
        tick();
        check("b2b hold valid", {31'h0, bus.res_valid}, 32'h1);
        check("b2b hold alu_x", bus.alu_x, 32'h5);
        bus.res_ack = 1'b1;
        #1;
        check("b2b ack ready", {31'h0, bus.ready}, 32'h1);
        tick();
        bus.res_ack = 1'b0;
        bus.start = 1'b0;
        check("b2b relaunch valid", {31'h0, bus.res_valid}, 32'h0);
        check("b2b relaunch alu_x", bus.alu_x, 32'h7);
        tick(); tick();
        check("b2b second valid", {31'h0, bus.res_valid}, 32'h1);
        check("b2b second res_out", bus.res_out, 32'd42);
        bus.res_ack = 1'b1;
        tick();
        check("b2b to idle", {31'h0, bus.ready}, 32'h1);
        // stray ack while idle
        tick();
        bus.res_ack = 1'b0;
        check("stray ack valid", {31'h0, bus.res_valid}, 32'h0);
        check("stray ack res_out", bus.res_out, 32'd42);
        check("stray ack alu_x", bus.alu_x, 32'h7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
